uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each byte the receiver presents on `Data_Rx`/`Data_Ready` and acknowledges it through the receiver's `CLR_Rec` input. Bytes are stored in a circular FIFO that a host or bus reader drains at its own pace. It also flags overruns and, optionally, filters bytes that carry a parity error.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 entries (8 by default).
- `CLK` in 1: system clock. All logic is on the rising edge.
- `CLR` in 1: reset, synchronous and active-high.
- `Data_Rx` in 8: received byte from the UART receiver. It is stable while `Data_Ready` is high.
- `Data_Ready` in 1: the receiver has a byte. It is a level held until acknowledged, and may be asynchronous to `CLK`.
- `parity_err` in 1: parity status of the byte on `Data_Rx`. It is valid while `Data_Ready` is high.
- `CLR_Rec` out 1: acknowledge/clear to the receiver.
- `Rd_En` in 1: read strobe, one entry per cycle.
- `Rd_Data` out 8: registered read data.
- `Empty` out 1: FIFO empty.
- `Full` out 1: FIFO full.
- `Count` out DEPTH_LOG2+1: number of stored entries, 0..2^DEPTH_LOG2.
- `Overrun` out 1: sticky flag, set when a byte is lost because the FIFO is full.
- `Err_Cnt` out 8: count of parity-rejected bytes. It saturates at 255.

## Operation
- **Reset values:** `CLR` high forces the following on the next edge:
  - outputs: `CLR_Rec`=0, `Rd_Data`=0x00, `Empty`=1, `Full`=0, `Count`=0, `Overrun`=0, `Err_Cnt`=0
  - internal: pointers=0, synchroniser=0, state=IDLE
  - Stored FIFO contents are not cleared.
  - A reset mid-handshake abandons the byte and drops `CLR_Rec` immediately.
- **Synchroniser:** `Data_Ready` passes through a 2-flop synchroniser to produce `rdy_s`. `Data_Rx` and `parity_err` are sampled only in CAPTURE, when they are known stable.
- **Handshake FSM:**
  - IDLE: when `rdy_s`=1, go to CAPTURE.
  - CAPTURE: one cycle. Perform the write decision below, then go to ACK.
  - ACK: `CLR_Rec`=1. Stay until `rdy_s`=0, then go to IDLE. `CLR_Rec`=0 in IDLE.
  - One byte is captured per `Data_Ready` assertion. A level held high never double-writes.
- **Write decision in CAPTURE:**
  - Parity-rejected (see Configuration): no write; `Err_Cnt`+1, saturating at 255.
  - Else if not `Full` or `Rd_En`=1 this cycle: write `Data_Rx` at `wr_ptr`; `wr_ptr`+1.
  - Else: byte dropped, `Overrun`=1. `Overrun` stays set until `CLR`.
- **Read:** `Rd_En`=1 with `Empty`=0 loads `Rd_Data` from `rd_ptr` and increments `rd_ptr`. `Rd_En` with `Empty`=1 is ignored; `Rd_Data` holds and pointers stay unchanged.
- **Pointers:** DEPTH_LOG2+1 bits, wrapping modulo 2^(DEPTH_LOG2+1).
  - `Empty` = (`wr_ptr`==`rd_ptr`).
  - `Full` = MSBs differ and the lower bits are equal.
  - `Count` = `wr_ptr`−`rd_ptr` in DEPTH_LOG2+1-bit arithmetic.
- **Simultaneous read and write:** the read returns the oldest entry and the write proceeds, including when `Full`. `Count` is unchanged. A write never bypasses to `Rd_Data` in the same cycle.

## Timing
- `Data_Ready` sampled high at edge n gives `rdy_s`=1 after edge n+1, CAPTURE after edge n+2, and `CLR_Rec`=1 after edge n+3.
- The write is visible in `Empty`/`Count` after edge n+3, the same edge on which `CLR_Rec` rises.
- `CLR_Rec` falls on the edge after `rdy_s` is seen low, i.e. 2–3 cycles after `Data_Ready` falls.
- Minimum per-byte turnaround is 6 `CLK` cycles plus the receiver's release delay.
- Read latency: `Rd_En` at edge k gives `Rd_Data` valid after edge k, and flags update on the same edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `UART_RX_PARITY_FILTER_EN` **defined:** a byte with `parity_err`=1 in CAPTURE is not written, `Err_Cnt` increments, and it is still acknowledged via `CLR_Rec`.
- `UART_RX_PARITY_FILTER_EN` **undefined:** `parity_err` is ignored, every byte is eligible for write, and `Err_Cnt` is held at 0.

## Test plan
- **Reset then single byte:** `CLR` 2 cycles; present 0x5A with `Data_Ready`=1.
  - `CLR_Rec` rises 3 cycles later; `Count`=1, `Empty`=0.
  - Drop `Data_Ready`: `CLR_Rec` falls within 3 cycles.
  - `Rd_En` 1 cycle: `Rd_Data`=0x5A, `Empty`=1.
- **Fill to full and overrun:** handshake 0x01..0x08 gives `Full`=1, `Count`=8. A 9th byte 0x09 gives `Overrun`=1 and is still acknowledged. Reading 8 times yields 0x01..0x08 in order.
- **Wrap-around:** write 5, read 5, then write 6 (0x10..0x15) and read 6: order preserved, `Count` returns to 0, pointers wrap with no spurious `Full`.
- **Full with read in CAPTURE cycle:** FIFO full; assert `Rd_En` exactly in the CAPTURE cycle of byte 0xAA. Required: `Overrun` stays 0, `Count` stays 8, and 0xAA becomes the last entry.
- **Parity filter:** with `UART_RX_PARITY_FILTER_EN` defined, byte 0x33 with `parity_err`=1 gives `Err_Cnt`=1, `Count` unchanged and `CLR_Rec` still pulsed. Without the macro, the same stimulus gives `Count`+1 and `Err_Cnt`=0.
- **Reset mid-handshake and empty read:** assert `CLR` while in ACK: `CLR_Rec`=0 on the next edge and `Count`=0. `Rd_En` while `Empty`: `Rd_Data` holds 0x00 and `Count` stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind a UART receiver.
// It synchronises the receiver's Data_Ready level and captures one byte per
// assertion. Each byte is acknowledged on CLR_Rec. Bytes are stored in a
// 2^DEPTH_LOG2-entry circular FIFO that a reader drains with Rd_En.
// Optional feature macro: UART_RX_PARITY_FILTER_EN. When it is defined,
// bytes that carry a parity error are acknowledged and counted, but they
// are not stored.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [7:0]            Data_Rx,
  input  logic                  Data_Ready,
  input  logic                  parity_err,
  output logic                  CLR_Rec,
  input  logic                  Rd_En,
  output logic [7:0]            Rd_Data,
  output logic                  Empty,
  output logic                  Full,
  output logic [DEPTH_LOG2:0]   Count,
  output logic                  Overrun,
  output logic [7:0]            Err_Cnt
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

  state_t      state;
  logic        rdy_m, rdy_s;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];

  logic cap, rej, rd_fire, wr_fire, drop;

  // Flags come straight from the pointer registers; there is no path from an input
  assign Empty = (wr_ptr == rd_ptr);
  assign Full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign Count = wr_ptr - rd_ptr;

  assign cap = (state == CAPTURE);

`ifdef UART_RX_PARITY_FILTER_EN
  assign rej = parity_err;
`else
  // Without the filter every byte is eligible; parity_err is deliberately ignored
  assign rej = parity_err & 1'b0;
`endif

  // A read in the CAPTURE cycle frees a slot, so a full FIFO can still accept the byte
  assign rd_fire = Rd_En && !Empty;
  assign wr_fire = cap && !rej && (!Full || Rd_En);
  assign drop    = cap && !rej && Full && !Rd_En;

  // Two-flop synchroniser for the asynchronous ready level
  always_ff @(posedge CLK) begin
    if (CLR) begin
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      rdy_m <= Data_Ready;
      rdy_s <= rdy_m;
    end
  end

  // Handshake FSM: capture once per ready level, then hold ack until ready drops
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= IDLE;
      CLR_Rec <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CLR_Rec <= 1'b0;
          if (rdy_s) state <= CAPTURE;
        end
        CAPTURE: begin
          CLR_Rec <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          if (!rdy_s) begin
            CLR_Rec <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          CLR_Rec <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Storage array; CLR leaves the contents alone
  always_ff @(posedge CLK) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= Data_Rx;
  end

  // Pointers, read data and the sticky overrun flag.
  // A read in the same cycle as a write sees the old entry, with no bypass.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      Rd_Data <= 8'h00;
      Overrun <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) begin
        Rd_Data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (drop) Overrun <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_FILTER_EN
  // Count parity-rejected bytes; the counter saturates at 255
  always_ff @(posedge CLK) begin
    if (CLR)                            Err_Cnt <= 8'h00;
    else if (cap && rej && Err_Cnt != 8'hFF) Err_Cnt <= Err_Cnt + 8'h01;
  end
`else
  assign Err_Cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo, built with the default depth of 8.
// It runs table-driven fill, overrun and wrap vectors, hand-written timing
// and corner sequences, and a randomized run checked against a queue-based
// model.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] Data_Rx = 8'h00;
  logic       Data_Ready = 1'b0;
  logic       parity_err = 1'b0;
  logic       CLR_Rec;
  logic       Rd_En = 1'b0;
  logic [7:0] Rd_Data;
  logic       Empty, Full, Overrun;
  logic [3:0] Count;
  logic [7:0] Err_Cnt;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef UART_RX_PARITY_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  uart_rx_fifo #(.DEPTH_LOG2(3)) dut (
    .CLK(CLK), .CLR(CLR), .Data_Rx(Data_Rx), .Data_Ready(Data_Ready),
    .parity_err(parity_err), .CLR_Rec(CLR_Rec), .Rd_En(Rd_En),
    .Rd_Data(Rd_Data), .Empty(Empty), .Full(Full), .Count(Count),
    .Overrun(Overrun), .Err_Cnt(Err_Cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    logic [3:0] exp_count;
    logic [7:0] exp_rd;
    bit         exp_full;
    bit         exp_ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    CLR = 1'b1; Data_Ready = 1'b0; Rd_En = 1'b0; parity_err = 1'b0;
    tick(); tick();
    CLR = 1'b0;
  endtask

  // Full receiver handshake with bounded waits on both ack edges
  task automatic send_byte(input logic [7:0] b, input logic perr);
    Data_Rx = b; parity_err = perr; Data_Ready = 1'b1;
    for (int i = 0; i < 8 && !CLR_Rec; i++) tick();
    chk("ack_rise", CLR_Rec, 1);
    Data_Ready = 1'b0;
    for (int i = 0; i < 6 && CLR_Rec; i++) tick();
    chk("ack_fall", CLR_Rec, 0);
  endtask

  task automatic read_one();
    Rd_En = 1'b1; tick(); Rd_En = 1'b0;
  endtask

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_rd;
  bit         m_ovr;
  int         m_err;

  initial begin
    logic [7:0] b;
    bit         pe;

    // ---------------- reset state
    do_reset();
    chk("rst_ack", CLR_Rec, 0);
    chk("rst_rd", Rd_Data, 8'h00);
    chk("rst_empty", Empty, 1);
    chk("rst_full", Full, 0);
    chk("rst_count", Count, 0);
    chk("rst_ovr", Overrun, 0);
    chk("rst_err", Err_Cnt, 0);

    // ---------------- single byte, exact latency
    Data_Rx = 8'h5A; Data_Ready = 1'b1;
    tick(); tick(); tick();
    chk("single_ack_early", CLR_Rec, 0);
    chk("single_cnt_early", Count, 0);
    tick();
    chk("single_ack", CLR_Rec, 1);
    chk("single_cnt", Count, 1);
    chk("single_empty", Empty, 0);
    Data_Ready = 1'b0;
    for (int i = 0; i < 3 && CLR_Rec; i++) tick();
    chk("single_ack_fall", CLR_Rec, 0);
    read_one();
    chk("single_rd", Rd_Data, 8'h5A);
    chk("single_empty2", Empty, 1);

    // ---------------- parity byte
    send_byte(8'h33, 1'b1);
    chk("par_count", Count, FILT ? 0 : 1);
    chk("par_err", Err_Cnt, FILT ? 1 : 0);

    // ---------------- table: fill, overrun, drain, wrap
    for (int i = 1; i <= 8; i++)
      tbl.push_back('{0, 8'(i), 4'(i), 8'h00, i == 8, 0});
    tbl.push_back('{0, 8'h09, 4'd8, 8'h00, 1, 1});
    for (int i = 1; i <= 8; i++)
      tbl.push_back('{1, 8'h00, 4'(8 - i), 8'(i), 0, 1});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 8'(8'h20 + i), 4'(i + 1), 8'h00, 0, 1});
    for (int i = 0; i < 5; i++) tbl.push_back('{1, 8'h00, 4'(4 - i), 8'(8'h20 + i), 0, 1});
    for (int i = 0; i < 6; i++) tbl.push_back('{0, 8'(8'h10 + i), 4'(i + 1), 8'h00, 0, 1});
    for (int i = 0; i < 6; i++) tbl.push_back('{1, 8'h00, 4'(5 - i), 8'(8'h10 + i), 0, 1});

    do_reset();
    foreach (tbl[k]) begin
      if (tbl[k].is_rd) begin
        read_one();
        chk("tbl_rd", Rd_Data, tbl[k].exp_rd);
      end else begin
        send_byte(tbl[k].data, 1'b0);
      end
      chk("tbl_count", Count, tbl[k].exp_count);
      chk("tbl_full", Full, tbl[k].exp_full);
      chk("tbl_empty", Empty, tbl[k].exp_count == 0);
      chk("tbl_ovr", Overrun, tbl[k].exp_ovr);
    end

    // ---------------- full FIFO, read exactly in the CAPTURE cycle
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hB0 + i), 1'b0);
    chk("fr_full", Full, 1);
    Data_Rx = 8'hAA; parity_err = 1'b0; Data_Ready = 1'b1;
    tick(); tick(); tick();
    Rd_En = 1'b1; tick(); Rd_En = 1'b0;
    chk("fr_ack", CLR_Rec, 1);
    chk("fr_rd", Rd_Data, 8'hB0);
    chk("fr_count", Count, 8);
    chk("fr_ovr", Overrun, 0);
    Data_Ready = 1'b0;
    for (int i = 0; i < 6 && CLR_Rec; i++) tick();
    chk("fr_ack_fall", CLR_Rec, 0);
    for (int i = 1; i < 8; i++) begin
      read_one();
      chk("fr_drain", Rd_Data, 8'(8'hB0 + i));
    end
    read_one();
    chk("fr_last", Rd_Data, 8'hAA);
    chk("fr_empty", Empty, 1);

    // ---------------- reset mid-handshake, then read while empty
    Data_Rx = 8'h77; Data_Ready = 1'b1;
    for (int i = 0; i < 8 && !CLR_Rec; i++) tick();
    chk("mid_ack", CLR_Rec, 1);
    CLR = 1'b1; Data_Ready = 1'b0;
    tick();
    chk("mid_ack_drop", CLR_Rec, 0);
    chk("mid_count", Count, 0);
    CLR = 1'b0;
    read_one();
    chk("mid_rd_hold", Rd_Data, 8'h00);
    chk("mid_count2", Count, 0);
    chk("mid_empty", Empty, 1);

    // ---------------- randomized run against the queue model
    do_reset();
    q.delete(); m_rd = 8'h00; m_ovr = 0; m_err = 0;
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        b  = 8'($urandom);
        pe = ($urandom_range(0, 3) == 0);
        send_byte(b, pe);
        if (FILT && pe) begin
          if (m_err < 255) m_err++;
        end else if (q.size() < 8) q.push_back(b);
        else m_ovr = 1;
      end else begin
        read_one();
        if (q.size() > 0) m_rd = q.pop_front();
      end
      chk("rnd_count", Count, q.size());
      chk("rnd_rd", Rd_Data, m_rd);
      chk("rnd_full", Full, q.size() == 8);
      chk("rnd_empty", Empty, q.size() == 0);
      chk("rnd_ovr", Overrun, m_ovr);
      chk("rnd_err", Err_Cnt, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
